// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - ID/EX stage bus: decode fields, RegFile/WB ports, control and EX outputs
interface id_ex_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_imm;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [4:0]        id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   rf_rdata1;
    logic [XLEN-1:0]   rf_rdata2;
    logic              wb_regwrite;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_wdata;
    logic              flush;
    logic              ext_stall;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_rdata1;
    logic [XLEN-1:0]   ex_rdata2;
    logic              stall_out;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite, id_ctrl, rf_rdata1, rf_rdata2,
               wb_regwrite, wb_rd, wb_wdata, flush, ext_stall,
        input  ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
               ex_memwrite, ex_ctrl, ex_rdata1, ex_rdata2, stall_out, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite, id_ctrl, rf_rdata1, rf_rdata2,
               wb_regwrite, wb_rd, wb_wdata, flush, ext_stall,
        output ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
               ex_memwrite, ex_ctrl, ex_rdata1, ex_rdata2, stall_out, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use bubble, flush, hold
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic   clk,
    input  logic   rst,
    id_ex_if.slave bus
);
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_rdata1;
    logic [XLEN-1:0]   ex_rdata2;
    logic [CNT_W-1:0]  bubble_cnt;

    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              hazard;
    logic              load_bubble;

    // WB write-through: the RegFile commits on the edge, so a same-cycle write is not yet visible
    always_comb begin
        op1 = bus.rf_rdata1;
        op2 = bus.rf_rdata2;
        if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1)) op1 = bus.wb_wdata;
        if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2)) op2 = bus.wb_wdata;
    end

    // Load-use: a load in EX whose result ID needs cannot be forwarded in time
    always_comb begin
        hazard = bus.id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                 ((bus.id_use_rs1 & (ex_rd == bus.id_rs1)) |
                  (bus.id_use_rs2 & (ex_rd == bus.id_rs2)));
        load_bubble = bus.flush | (~bus.ext_stall & (hazard | ~bus.id_valid));
    end

    // Pipeline register: flush > hold > hazard bubble > normal load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_ctrl     <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
        end else if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_ctrl     <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
        end else if (!bus.ext_stall) begin
            ex_valid    <= 1'b1;
            ex_pc       <= bus.id_pc;
            ex_imm      <= bus.id_imm;
            ex_rs1      <= bus.id_rs1;
            ex_rs2      <= bus.id_rs2;
            ex_rd       <= bus.id_rd;
            ex_regwrite <= bus.id_regwrite;
            ex_memread  <= bus.id_memread;
            ex_memwrite <= bus.id_memwrite;
            ex_ctrl     <= bus.id_ctrl;
            ex_rdata1   <= op1;
            ex_rdata2   <= op2;
        end
    end

    // Saturating count of load-use bubbles; flush or hold take precedence and do not count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!bus.flush && !bus.ext_stall && hazard && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_valid    = ex_valid;
    assign bus.ex_pc       = ex_pc;
    assign bus.ex_imm      = ex_imm;
    assign bus.ex_rs1      = ex_rs1;
    assign bus.ex_rs2      = ex_rs2;
    assign bus.ex_rd       = ex_rd;
    assign bus.ex_regwrite = ex_regwrite;
    assign bus.ex_memread  = ex_memread;
    assign bus.ex_memwrite = ex_memwrite;
    assign bus.ex_ctrl     = ex_ctrl;
    assign bus.ex_rdata1   = ex_rdata1;
    assign bus.ex_rdata2   = ex_rdata2;
    assign bus.stall_out   = ~bus.flush & (bus.ext_stall | hazard);
    assign bus.bubble_cnt  = bubble_cnt;
endmodule
